// File: rtl/dram_traffic_gen.sv
// DRAM traffic generator: writes NUM_BURSTS bursts of a pattern, reads them back and counts mismatches.
// Optional PRBS31 pattern (mode 2) built only when DRAM_TG_PRBS_EN is defined; otherwise mode 2 acts as mode 0.
module dram_traffic_gen #(
    parameter int DWIDTH     = 64,
    parameter int AWIDTH     = 30,
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [AWIDTH-1:0] base_addr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [AWIDTH-1:0] cmd_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    input  logic [DWIDTH-1:0] rd_data,
    input  logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       err_count,
    output logic [AWIDTH-1:0] first_err_addr
);

    localparam int NREP = DWIDTH / 32;
    localparam int LW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BW   = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int PW   = $clog2(DWIDTH);

    localparam logic [AWIDTH-1:0] BURST_BYTES = AWIDTH'(BURST_LEN * (DWIDTH / 8));
    localparam logic [LW-1:0]     LAST_BEAT   = LW'(BURST_LEN - 1);
    localparam logic [BW-1:0]     LAST_BURST  = BW'(NUM_BURSTS - 1);
    localparam logic [PW-1:0]     LAST_POS    = PW'(DWIDTH - 1);
    localparam logic [LW-1:0]     BEAT_ONE    = LW'(1);
    localparam logic [BW-1:0]     BURST_ONE   = BW'(1);
    localparam logic [PW-1:0]     POS_ONE     = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_mode;
    logic [AWIDTH-1:0]   r_base;
    logic [AWIDTH-1:0]   r_cmd_addr;
    logic [LW-1:0]       r_beat;
    logic [BW-1:0]       r_burst;
    logic [31:0]         r_w;
    logic [PW-1:0]       r_pos;
    logic                r_error;
    logic [31:0]         r_err_count;
    logic [AWIDTH-1:0]   r_first_err;
    logic [DWIDTH-1:0]   w_pattern;
    logic [DWIDTH-1:0]   w_onehot;
    logic                w_start, w_wr_fire, w_rd_fire;
    logic                w_last_beat, w_last_burst, w_mismatch;
    logic                w_rewind, w_advance;
`ifdef DRAM_TG_PRBS_EN
    logic [31:0]         r_lfsr;
`endif

    assign w_start      = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_wr_fire    = (r_state == S_WR_DATA) & wr_ready;
    assign w_rd_fire    = (r_state == S_RD_DATA) & rd_valid;
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_last_burst = (r_burst == LAST_BURST);
    assign w_mismatch   = (rd_data != w_pattern);
    // Pattern restarts at pass start and again when the read phase begins.
    assign w_rewind     = w_start | (w_wr_fire & w_last_beat & w_last_burst);
    assign w_advance    = w_wr_fire | w_rd_fire;

    assign cmd_addr       = r_cmd_addr;
    assign error          = r_error;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_pos] = 1'b1;
        case (r_mode)
            2'd1:    w_pattern = w_onehot;
`ifdef DRAM_TG_PRBS_EN
            2'd2:    w_pattern = {NREP{r_lfsr}};
`endif
            default: w_pattern = {NREP{r_w}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        wr_valid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_WR_CMD;
            end
            S_WR_CMD: begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b1;
                if (cmd_ready) w_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                wr_valid = 1'b1;
                if (wr_ready && w_last_beat) w_next = w_last_burst ? S_RD_CMD : S_WR_CMD;
            end
            S_RD_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rd_valid && w_last_beat) w_next = w_last_burst ? S_DONE : S_RD_CMD;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) w_next = S_WR_CMD;
            end
            default: w_next = S_IDLE;
        endcase
        wr_data = wr_valid ? w_pattern : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= '0;
            r_base      <= '0;
            r_cmd_addr  <= '0;
            r_beat      <= '0;
            r_burst     <= '0;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            if (w_start) begin
                r_mode      <= mode;
                r_base      <= base_addr;
                r_cmd_addr  <= base_addr;
                r_beat      <= '0;
                r_burst     <= '0;
                r_error     <= 1'b0;
                r_err_count <= '0;
                r_first_err <= '0;
            end
            if (w_advance) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    if (w_last_burst) begin
                        r_burst    <= '0;
                        r_cmd_addr <= r_base;
                    end else begin
                        r_burst    <= r_burst + BURST_ONE;
                        r_cmd_addr <= r_cmd_addr + BURST_BYTES;
                    end
                end else begin
                    r_beat <= r_beat + BEAT_ONE;
                end
            end
            // r_cmd_addr still holds the address of the burst being read here.
            if (w_rd_fire && w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_count != 32'hFFFF_FFFF) r_err_count <= r_err_count + 32'd1;
                if (!r_error) r_first_err <= r_cmd_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_rewind) begin
            r_w   <= '0;
            r_pos <= '0;
        end else if (w_advance) begin
            r_w   <= r_w + 32'd1;
            r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + POS_ONE;
        end
    end

`ifdef DRAM_TG_PRBS_EN
    // PRBS31 (x^31 + x^28 + 1) shifted through a 32-bit word.
    always_ff @(posedge clk) begin
        if (reset || w_rewind) r_lfsr <= 32'h0000_0001;
        else if (w_advance)    r_lfsr <= {r_lfsr[30:0], r_lfsr[30] ^ r_lfsr[27]};
    end
`endif

endmodule
